// File: rtl/hw5_pkg.sv
// Shared definitions for the hw5 ALU result path.
// Used by the ALU, the result sink and their benches.
package hw5_pkg;

   localparam int WIDTH    = 32;
   localparam int DATABITS = 7;

   typedef enum logic [1:0] {
      OP_NOP  = 2'd0,
      OP_ADD  = 2'd1,
      OP_SUB  = 2'd2,
      OP_MULT = 2'd3
   } hw5_op_e;

   typedef struct packed {
      logic [WIDTH-1:0]    result;
      logic [DATABITS-1:0] tag;
      logic [1:0]          op;
   } hw5_res_t;

endpackage

// File: rtl/hw5_fwft_fifo.sv
// First-word-fall-through FIFO; head is read straight from storage.
// Occupancy is tracked apart from the pointers so full/empty differ.
module hw5_fwft_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [DW-1:0]            data_i,
   input  logic                     pop_i,
   output logic [DW-1:0]            data_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] last_ptr, head_ptr;
   logic [LW-1:0] level_q, level_d;
   logic          do_push, do_pop;

   assign empty_o = (level_q == '0);
   assign full_o  = (level_q == LW'(DEPTH));
   assign level_o = level_q;

   // A pop frees a slot in the same edge, so a full FIFO can still take a push.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // When empty, keep showing the last word that left so outputs hold.
   assign last_ptr = rd_ptr_q - 1'b1;
   assign head_ptr = empty_o ? last_ptr : rd_ptr_q;
   assign data_o   = mem_q[head_ptr];

   // Next pointers and occupancy.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage; cleared on reset so the idle head reads as zero.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/hw5_result_sink.sv
// Receive end of the hw5 ALU result stream: buffers non-NOP results,
// checks tag sequencing and keeps per-op statistics.
module hw5_result_sink
   import hw5_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNTW  = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       in_result,
   input  logic [DATABITS-1:0]    in_tag,
   input  logic [1:0]             in_op,
   input  logic                   clear,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_result,
   output logic [DATABITS-1:0]    out_tag,
   output logic [1:0]             out_op,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow,
   output logic                   tag_err,
   output logic [CNTW-1:0]        drop_count,
   output logic [CNTW-1:0]        add_count,
   output logic [CNTW-1:0]        sub_count,
   output logic [CNTW-1:0]        mult_count
);

   hw5_res_t in_rec, head_rec;
   logic     push, pop, accept, drop;
   logic     full, empty;

   logic [DATABITS-1:0] exp_tag_q, exp_tag_d;
   logic                tag_err_q, tag_err_d;
   logic                ovf_q, ovf_d;
   logic [CNTW-1:0]     drop_q, drop_d;
   logic [CNTW-1:0]     add_q, add_d;
   logic [CNTW-1:0]     sub_q, sub_d;
   logic [CNTW-1:0]     mult_q, mult_d;

   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign in_rec = '{result: in_result, tag: in_tag, op: in_op};

   // The ALU cannot be stalled: anything that does not fit is dropped.
   assign push   = (in_op != OP_NOP);
   assign pop    = out_valid && out_ready;
   assign accept = push && (!full || pop);
   assign drop   = push && !accept;

   hw5_fwft_fifo #(
      .DW    ($bits(hw5_res_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (reset),
      .push_i  (accept),
      .data_i  (in_rec),
      .pop_i   (pop),
      .data_o  (head_rec),
      .level_o (level),
      .full_o  (full),
      .empty_o (empty)
   );

   assign out_valid  = !empty;
   assign out_result = head_rec.result;
   assign out_tag    = head_rec.tag;
   assign out_op     = head_rec.op;

   assign overflow   = ovf_q;
   assign tag_err    = tag_err_q;
   assign drop_count = drop_q;
   assign add_count  = add_q;
   assign sub_count  = sub_q;
   assign mult_count = mult_q;

   // Tag tracking resyncs on every accepted push; clear beats any event.
   always_comb begin
      exp_tag_d = exp_tag_q;
      tag_err_d = tag_err_q;
      ovf_d     = ovf_q;
      drop_d    = drop_q;
      add_d     = add_q;
      sub_d     = sub_q;
      mult_d    = mult_q;
      if (accept) exp_tag_d = in_tag + 1'b1;
      if (clear) begin
         tag_err_d = 1'b0;
         ovf_d     = 1'b0;
         drop_d    = '0;
         add_d     = '0;
         sub_d     = '0;
         mult_d    = '0;
      end else begin
         if (drop) begin
            ovf_d  = 1'b1;
            drop_d = sat_inc(drop_q);
         end
         if (accept) begin
            if (in_tag != exp_tag_q) tag_err_d = 1'b1;
            unique case (in_op)
               OP_ADD:  add_d  = sat_inc(add_q);
               OP_SUB:  sub_d  = sat_inc(sub_q);
               OP_MULT: mult_d = sat_inc(mult_q);
               OP_NOP:  ;
            endcase
         end
      end
   end

   // Statistic and tag registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         exp_tag_q <= '0;
         tag_err_q <= 1'b0;
         ovf_q     <= 1'b0;
         drop_q    <= '0;
         add_q     <= '0;
         sub_q     <= '0;
         mult_q    <= '0;
      end else begin
         exp_tag_q <= exp_tag_d;
         tag_err_q <= tag_err_d;
         ovf_q     <= ovf_d;
         drop_q    <= drop_d;
         add_q     <= add_d;
         sub_q     <= sub_d;
         mult_q    <= mult_d;
      end
   end

endmodule

// File: tb/tb_hw5_result_sink.sv
// Scoreboard bench for hw5_result_sink.
// Expected results are queued on drive and compared on handshake.
module tb_hw5_result_sink;
   import hw5_pkg::*;

   localparam int D = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] in_result;
   logic [6:0]  in_tag;
   logic [1:0]  in_op;
   logic        clear;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [6:0]  out_tag;
   logic [1:0]  out_op;
   logic [3:0]  level;
   logic        overflow;
   logic        tag_err;
   logic [15:0] drop_count;
   logic [15:0] add_count;
   logic [15:0] sub_count;
   logic [15:0] mult_count;

   hw5_res_t sbq[$];
   int       mlevel;
   int       maxlvl;
   int       n_chk;
   int       n_pass;

   hw5_result_sink #(.DEPTH(D), .CNTW(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_result  (in_result),
      .in_tag     (in_tag),
      .in_op      (in_op),
      .clear      (clear),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_tag    (out_tag),
      .out_op     (out_op),
      .level      (level),
      .overflow   (overflow),
      .tag_err    (tag_err),
      .drop_count (drop_count),
      .add_count  (add_count),
      .sub_count  (sub_count),
      .mult_count (mult_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // One clock: drive at edge+1, check head at negedge, advance model.
   task automatic cyc(input logic [1:0] op, input logic [6:0] tag,
                      input logic [31:0] res, input logic rdy);
      bit       acc, popm;
      hw5_res_t e;
      in_op     = op;
      in_tag    = tag;
      in_result = res;
      out_ready = rdy;
      popm = (mlevel > 0) && rdy;
      acc  = (op != 2'd0) && ((mlevel < D) || popm);
      @(negedge clk);
      chk("out_valid", 32'(out_valid), 32'(mlevel > 0));
      chk("level", 32'(level), 32'(mlevel));
      if (popm) begin
         e = sbq.pop_front();
         chk("out_result", out_result, e.result);
         chk("out_tag", 32'(out_tag), 32'(e.tag));
         chk("out_op", 32'(out_op), 32'(e.op));
      end
      if (acc) sbq.push_back('{result: res, tag: tag, op: op});
      @(posedge clk);
      #1;
      mlevel = mlevel + int'(acc) - int'(popm);
      if (mlevel > maxlvl) maxlvl = mlevel;
      in_op     = 2'd0;
      out_ready = 1'b0;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) cyc(2'd0, 7'd0, 32'd0, 1'b1);
   endtask

   task automatic do_reset();
      in_op = 2'd0;
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset  = 1'b1;
      mlevel = 0;
      maxlvl = 0;
      sbq.delete();
   endtask

   initial begin
      n_chk = 0; n_pass = 0; mlevel = 0; maxlvl = 0;
      reset = 1'b0; clear = 1'b0; out_ready = 1'b0;
      in_op = 2'd0; in_tag = '0; in_result = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_level", 32'(level), 0);
      chk("rst_result", out_result, 0);
      chk("rst_tag", 32'(out_tag), 0);
      chk("rst_op", 32'(out_op), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_tagerr", 32'(tag_err), 0);
      chk("rst_counts", 32'(drop_count | add_count | sub_count | mult_count), 0);
      reset = 1'b1;

      // Streaming ADDs with the consumer always ready.
      cyc(2'd1, 7'd0, 32'd5, 1'b1);
      cyc(2'd1, 7'd1, 32'd7, 1'b1);
      cyc(2'd1, 7'd2, 32'd9, 1'b1);
      drain(2);
      chk("t1_add", 32'(add_count), 3);
      chk("t1_tagerr", 32'(tag_err), 0);
      chk("t1_maxlvl", 32'(maxlvl), 1);

      // Fill, overflow by one, drain, then expected tag continues at 8.
      do_reset();
      for (int i = 0; i < 8; i++) cyc(2'd2, 7'(i), 32'h200 + i, 1'b0);
      cyc(2'd2, 7'd8, 32'h208, 1'b0);
      chk("t2_level", 32'(level), 8);
      chk("t2_ovf", 32'(overflow), 1);
      chk("t2_drop", 32'(drop_count), 1);
      chk("t2_sub", 32'(sub_count), 8);
      chk("t2_tagerr", 32'(tag_err), 0);
      drain(8);
      cyc(2'd2, 7'd8, 32'h308, 1'b1);
      chk("t2_exptag", 32'(tag_err), 0);
      chk("t2_sub9", 32'(sub_count), 9);
      drain(1);

      // Full FIFO with a simultaneous pop still takes the push.
      do_reset();
      for (int i = 0; i < 8; i++) cyc(2'd2, 7'(i), 32'h400 + i, 1'b0);
      cyc(2'd2, 7'd8, 32'h408, 1'b1);
      chk("t3_level", 32'(level), 8);
      chk("t3_ovf", 32'(overflow), 0);
      drain(8);
      chk("t3_sub", 32'(sub_count), 9);
      chk("t3_drop", 32'(drop_count), 0);

      // Tag wrap, mismatch resync and clear.
      do_reset();
      cyc(2'd1, 7'd125, 32'h500, 1'b0);
      chk("t4_err0", 32'(tag_err), 1);
      clear = 1'b1;
      cyc(2'd0, 7'd0, 32'd0, 1'b0);
      clear = 1'b0;
      chk("t4_clr_err", 32'(tag_err), 0);
      chk("t4_clr_add", 32'(add_count), 0);
      chk("t4_clr_lvl", 32'(level), 1);
      cyc(2'd1, 7'd126, 32'h501, 1'b0);
      cyc(2'd1, 7'd127, 32'h502, 1'b0);
      cyc(2'd1, 7'd0, 32'h503, 1'b0);
      chk("t4_wrap", 32'(tag_err), 0);
      chk("t4_add3", 32'(add_count), 3);
      cyc(2'd1, 7'd5, 32'h504, 1'b0);
      chk("t4_err5", 32'(tag_err), 1);
      clear = 1'b1;
      cyc(2'd0, 7'd0, 32'd0, 1'b0);
      clear = 1'b0;
      chk("t4_clr2_err", 32'(tag_err), 0);
      chk("t4_clr2_add", 32'(add_count), 0);
      chk("t4_clr2_lvl", 32'(level), 5);
      cyc(2'd1, 7'd6, 32'h505, 1'b0);
      chk("t4_resync", 32'(tag_err), 0);
      chk("t4_add1", 32'(add_count), 1);
      clear = 1'b1;
      cyc(2'd1, 7'd7, 32'h506, 1'b0);
      clear = 1'b0;
      chk("t4_clrwin", 32'(add_count), 0);
      chk("t4_lvl7", 32'(level), 7);
      cyc(2'd1, 7'd9, 32'h507, 1'b0);
      chk("t4_err9", 32'(tag_err), 1);
      drain(8);

      // Op mix with NOPs.
      do_reset();
      cyc(2'd1, 7'd0, 32'h600, 1'b0);
      cyc(2'd0, 7'd0, 32'h6ff, 1'b0);
      cyc(2'd3, 7'd1, 32'h601, 1'b0);
      cyc(2'd0, 7'd0, 32'h6fe, 1'b0);
      cyc(2'd2, 7'd2, 32'h602, 1'b0);
      cyc(2'd3, 7'd3, 32'h603, 1'b0);
      chk("t5_level", 32'(level), 4);
      chk("t5_add", 32'(add_count), 1);
      chk("t5_sub", 32'(sub_count), 1);
      chk("t5_mult", 32'(mult_count), 2);
      chk("t5_tagerr", 32'(tag_err), 0);
      drain(4);

      // Asynchronous reset with data buffered.
      do_reset();
      cyc(2'd1, 7'd0, 32'h700, 1'b0);
      cyc(2'd1, 7'd1, 32'h701, 1'b0);
      cyc(2'd1, 7'd2, 32'h702, 1'b0);
      chk("t6_pre_lvl", 32'(level), 3);
      #2;
      reset = 1'b0;
      #1;
      chk("t6_valid", 32'(out_valid), 0);
      chk("t6_level", 32'(level), 0);
      chk("t6_add", 32'(add_count), 0);
      chk("t6_flags", 32'({overflow, tag_err}), 0);
      sbq.delete();
      mlevel = 0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      cyc(2'd1, 7'd0, 32'h710, 1'b1);
      chk("t6_tag0", 32'(tag_err), 0);
      drain(1);
      chk("t6_empty", 32'(sbq.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/hw5_result_sink.md
Name: hw5_result_sink

Overview:
- Receive end of the hw5_unit ALU result interface (res / out_databits / out_op).
- Captures every non-NOP result the pipeline emits and buffers it in a small first-word-fall-through FIFO.
- Presents buffered results downstream with a valid/ready handshake.
- Checks tag sequencing and keeps per-op statistics, so a bench or host can consume results at its own pace without losing any.

Parameters:
- WIDTH, 32, result data width (matches ALU operands).
- DATABITS, 7, tag width.
- DEPTH, 8, FIFO entries; power of two, >= 2.
- CNTW, 16, width of statistic counters.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_result  input  WIDTH  ALU res.
- in_tag  input  DATABITS  ALU out_databits.
- in_op  input  2  ALU out_op; 0=NOP (no result), 1=ADD, 2=SUB, 3=MULT.
- clear  input  1  synchronous clear of sticky flags and counters; does not touch FIFO or expected tag.
- out_valid  output  1  FIFO head holds a result.
- out_ready  input  1  consumer accepts head this cycle.
- out_result  output  WIDTH  head result.
- out_tag  output  DATABITS  head tag.
- out_op  output  2  head op.
- level  output  log2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky: a result was dropped.
- tag_err  output  1  sticky: a tag arrived out of sequence.
- drop_count  output  CNTW  results dropped.
- add_count / sub_count / mult_count  output  CNTW each  accepted results per op.

Behaviour:
- Reset (reset low, asynchronous):
  - FIFO empty: wr_ptr=rd_ptr=0, level=0, out_valid=0.
  - out_result/out_tag/out_op=0.
  - overflow=tag_err=0; all counters=0; expected tag=0.
  - Reset mid-stream discards all buffered data.
- push = (in_op != 0). No backpressure to the ALU; inputs are sampled every edge.
- pop = out_valid && out_ready.
- Push accepted when level<DEPTH, or level==DEPTH with a simultaneous pop (pop frees the slot in the same edge).
- Push not accepted:
  - drop the result, set overflow, drop_count += 1 (saturating).
  - A dropped result is not tag-checked and does not update the expected tag or op counters.
- Latency: a result accepted at edge N appears on out_* with out_valid=1 after edge N. Zero bubble; first-word fall-through, head driven from storage.
- Simultaneous push and pop: level unchanged.
  - When level==1, the popped word leaves and the pushed word becomes the head after the edge.
- out_* hold stable while out_valid && !out_ready.
- When out_valid=0, out_* hold their last value; there is no requirement to zero them.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. level is tracked separately so full and empty are distinguishable.
- Tag check on each accepted push:
  - in_tag != expected sets tag_err.
  - expected := in_tag + 1 mod 2^DATABITS, either way (resync after a mismatch).
  - Wrap 127→0 is legal and is not an error.
- Op counters: the counter matching in_op increments on an accepted push and saturates at all-ones.
- clear: zeroes overflow, tag_err and all counters at the edge.
  - If an event coincides with clear, clear wins; the event is lost from the statistics.
  - FIFO contents and expected tag are unaffected.
- State machine: none beyond the FIFO (empty / partial / full, derived from level).

Decomposition:
- Shared package hw5_pkg: WIDTH, DATABITS, op encodings OP_NOP/OP_ADD/OP_SUB/OP_MULT, and a result record typedef {result, tag, op}. The ALU and its bench use the same definitions.
- One natural sub-module, hw5_fwft_fifo, parameterised on data width and DEPTH, with push/pop/level/full/empty.
  - Tag checking and counters stay in hw5_result_sink.

Test Plan:
- Reset, then ADD results tags 0,1,2 (res=5,7,9) on consecutive cycles, out_ready=1 → out_valid one cycle after each push; out_result 5,7,9 in order; add_count=3; tag_err=0; level never exceeds 1.
- out_ready=0, push 8 SUB results tags 0..7, then a 9th (tag 8) → level=8, overflow=1, drop_count=1, sub_count=8. Draining yields tags 0..7; expected tag is 8.
- Full FIFO with out_ready=1 and a simultaneous push (tag 8) → accepted; level stays 8; overflow stays 0; tag 8 emerges last.
- Tags 126,127,0 accepted → tag_err=0. Then tag 5 → tag_err=1, and next expected is 6; tag 6 does not change the flag. Assert clear → tag_err=0, counters=0, FIFO level unchanged.
- Interleaved NOP cycles and an op mix ADD,MULT,NOP,SUB,MULT → level=4; counts ADD=1, SUB=1, MULT=2; NOPs are never stored.
- Assert reset low mid-cycle with 3 entries buffered → out_valid drops immediately (asynchronously), level=0, all flags and counters 0. After release, tag 0 is accepted without tag_err.
